layer1_feedback_conditioner: RTL and testbench

Upstream conditioner for the Layer 1 apical-gain stage. It scales and low-pass filters three raw drive signals (matrix thalamic, adjacent-column feedback, distant-column feedback) and produces the bounded, smoothed `matrix_thalamic_input`, `feedback_input_1` and `feedback_input_2` values that the gain stage consumes.
- One time-shared multiplier, sequenced by a small FSM, once per `clk_en` strobe.
- All values are signed Q4.14.

---
 rtl/layer1_feedback_conditioner_pkg.sv | 30 +++
 rtl/layer1_feedback_conditioner_fb_ema_update.sv | 34 +++
 rtl/layer1_feedback_conditioner.sv | 147 ++++++++++++++
 tb/tb_layer1_feedback_conditioner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/layer1_feedback_conditioner_pkg.sv
// Shared Q4.14 constants, saturation helper and FSM state encoding for the
// Layer 1 feedback conditioner.
package layer1_feedback_conditioner_pkg;

   localparam int Q_ONE = 16384;
   localparam int Q_TWO = 32768;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CH0    = 3'd1,
      ST_CH1    = 3'd2,
      ST_CH2    = 3'd3,
      ST_COMMIT = 3'd4
   } fsm_state_t;

   // Symmetric clamp of a wide signed value to [-lim, +lim].
   function automatic logic signed [63:0] sat_bound(
      input logic signed [63:0] v,
      input logic signed [63:0] lim
   );
      logic signed [63:0] r;
      r = v;
      if (v > lim)
         r = lim;
      else if (v < -lim)
         r = -lim;
      return r;
   endfunction

endpackage

// File: rtl/layer1_feedback_conditioner_fb_ema_update.sv
// One channel step: scale by a Q4.14 weight, clamp, then a 2^-ALPHA_SHIFT EMA
// update with floor rounding. Purely combinational; shared across channels.
module fb_ema_update
   import layer1_feedback_conditioner_pkg::*;
#(
   parameter int WIDTH       = 18,
   parameter int FRAC        = 14,
   parameter int ALPHA_SHIFT = 2,
   parameter int SAT_LIMIT   = Q_TWO
) (
   input  logic signed [WIDTH-1:0] i_x,
   input  logic signed [WIDTH-1:0] i_k,
   input  logic signed [WIDTH-1:0] i_ema,
   output logic signed [WIDTH-1:0] o_ema_next
);

   logic signed [2*WIDTH-1:0] w_prod;
   logic signed [2*WIDTH-1:0] w_scaled;
   logic signed [WIDTH-1:0]   w_clamped;
   logic signed [WIDTH+1:0]   w_diff;
   logic signed [WIDTH+1:0]   w_step;
   logic signed [WIDTH+1:0]   w_sum;

   assign w_prod    = i_x * i_k;
   assign w_scaled  = w_prod >>> FRAC;
   assign w_clamped = WIDTH'(sat_bound(64'(w_scaled), 64'(SAT_LIMIT)));

   // Two guard bits keep (target - ema) exact when both sit near opposite rails.
   assign w_diff     = (WIDTH+2)'(w_clamped) - (WIDTH+2)'(i_ema);
   assign w_step     = w_diff >>> ALPHA_SHIFT;
   assign w_sum      = (WIDTH+2)'(i_ema) + w_step;
   assign o_ema_next = WIDTH'(w_sum);

endmodule

// File: rtl/layer1_feedback_conditioner.sv
// Scales and smooths the matrix / adjacent / distant drive signals with one
// time-shared multiplier, committing all three outputs together.
module layer1_feedback_conditioner
   import layer1_feedback_conditioner_pkg::*;
#(
   parameter int WIDTH       = 18,
   parameter int FRAC        = 14,
   parameter int ALPHA_SHIFT = 2,
   parameter int SAT_LIMIT   = Q_TWO,
   parameter int K_MATRIX    = Q_ONE,
   parameter int K_FB1       = Q_ONE,
   parameter int K_FB2       = Q_ONE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clk_en,
   input  logic                    clear,
   input  logic signed [WIDTH-1:0] matrix_raw,
   input  logic signed [WIDTH-1:0] fb1_raw,
   input  logic signed [WIDTH-1:0] fb2_raw,
   output logic signed [WIDTH-1:0] matrix_thalamic_input,
   output logic signed [WIDTH-1:0] feedback_input_1,
   output logic signed [WIDTH-1:0] feedback_input_2,
   output logic                    out_valid,
   output logic                    busy,
   output logic [7:0]              overrun_count
);

   localparam logic signed [WIDTH-1:0] L_K_MATRIX = WIDTH'(K_MATRIX);
   localparam logic signed [WIDTH-1:0] L_K_FB1    = WIDTH'(K_FB1);
   localparam logic signed [WIDTH-1:0] L_K_FB2    = WIDTH'(K_FB2);

   fsm_state_t r_state;
   fsm_state_t w_state_next;

   logic signed [WIDTH-1:0] r_x   [3];
   logic signed [WIDTH-1:0] r_ema [3];
   logic signed [WIDTH-1:0] r_out [3];
   logic                    r_out_valid;
   logic [7:0]              r_overrun;

   logic                    w_busy;
   logic signed [WIDTH-1:0] w_sel_x;
   logic signed [WIDTH-1:0] w_sel_k;
   logic signed [WIDTH-1:0] w_sel_ema;
   logic signed [WIDTH-1:0] w_ema_next;

   assign w_busy = (r_state != ST_IDLE);

   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:   if (clk_en) w_state_next = ST_CH0;
            ST_CH0:    w_state_next = ST_CH1;
            ST_CH1:    w_state_next = ST_CH2;
            ST_CH2:    w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
         endcase
      end
   end

   // Route the channel owned by the current state into the shared datapath.
   always_comb begin
      w_sel_x   = r_x[0];
      w_sel_k   = L_K_MATRIX;
      w_sel_ema = r_ema[0];
      case (r_state)
         ST_CH1: begin
            w_sel_x   = r_x[1];
            w_sel_k   = L_K_FB1;
            w_sel_ema = r_ema[1];
         end
         ST_CH2: begin
            w_sel_x   = r_x[2];
            w_sel_k   = L_K_FB2;
            w_sel_ema = r_ema[2];
         end
         default: ;
      endcase
   end

   fb_ema_update #(
      .WIDTH       (WIDTH),
      .FRAC        (FRAC),
      .ALPHA_SHIFT (ALPHA_SHIFT),
      .SAT_LIMIT   (SAT_LIMIT)
   ) u_ema (
      .i_x        (w_sel_x),
      .i_k        (w_sel_k),
      .i_ema      (w_sel_ema),
      .o_ema_next (w_ema_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_out_valid <= 1'b0;
         r_overrun   <= 8'd0;
         for (int i = 0; i < 3; i++) begin
            r_x[i]   <= '0;
            r_ema[i] <= '0;
            r_out[i] <= '0;
         end
      end else begin
         r_state     <= w_state_next;
         r_out_valid <= 1'b0;
         if (clear) begin
            for (int i = 0; i < 3; i++) begin
               r_ema[i] <= '0;
               r_out[i] <= '0;
            end
         end else begin
            if (r_state == ST_IDLE && clk_en) begin
               r_x[0] <= matrix_raw;
               r_x[1] <= fb1_raw;
               r_x[2] <= fb2_raw;
            end
            // A strobe that arrives mid-computation is dropped, only counted.
            if (w_busy && clk_en && r_overrun != 8'hFF)
               r_overrun <= r_overrun + 8'd1;
            case (r_state)
               ST_CH0: r_ema[0] <= w_ema_next;
               ST_CH1: r_ema[1] <= w_ema_next;
               ST_CH2: r_ema[2] <= w_ema_next;
               ST_COMMIT: begin
                  for (int i = 0; i < 3; i++)
                     r_out[i] <= r_ema[i];
                  r_out_valid <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign matrix_thalamic_input = r_out[0];
   assign feedback_input_1      = r_out[1];
   assign feedback_input_2      = r_out[2];
   assign out_valid             = r_out_valid;
   assign busy                  = w_busy;
   assign overrun_count         = r_overrun;

endmodule

// File: tb/tb_layer1_feedback_conditioner.sv
// Directed bench for layer1_feedback_conditioner: table-driven EMA vectors plus
// hand-written overrun, clear and mid-flight reset sequences.
module tb_layer1_feedback_conditioner;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                clk_en;
   logic                clear;
   logic signed [17:0]  matrix_raw, fb1_raw, fb2_raw;
   logic signed [17:0]  mti, fbi1, fbi2;
   logic                out_valid, busy;
   logic [7:0]          overrun_count;
   logic signed [17:0]  k_mti, k_fbi1, k_fbi2;
   logic                k_out_valid, k_busy;
   logic [7:0]          k_overrun;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   layer1_feedback_conditioner u_dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clear(clear),
      .matrix_raw(matrix_raw), .fb1_raw(fb1_raw), .fb2_raw(fb2_raw),
      .matrix_thalamic_input(mti), .feedback_input_1(fbi1), .feedback_input_2(fbi2),
      .out_valid(out_valid), .busy(busy), .overrun_count(overrun_count)
   );

   // Second instance with a 2.0 adjacent weight to exercise the clamp.
   layer1_feedback_conditioner #(.K_FB1(32768)) u_dut_k (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clear(clear),
      .matrix_raw(matrix_raw), .fb1_raw(fb1_raw), .fb2_raw(fb2_raw),
      .matrix_thalamic_input(k_mti), .feedback_input_1(k_fbi1), .feedback_input_2(k_fbi2),
      .out_valid(k_out_valid), .busy(k_busy), .overrun_count(k_overrun)
   );

   typedef struct {
      int m, f1, f2;
      int em, ef1, ef2;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic set_raw(input int m, input int f1, input int f2);
      matrix_raw = 18'(m);
      fb1_raw    = 18'(f1);
      fb2_raw    = 18'(f2);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Single strobe; reports edges until first out_valid and how many pulses.
   task automatic run_strobe(output int lat, output int nvalid);
      clk_en = 1'b1;
      @(posedge clk); #1;
      clk_en = 1'b0;
      lat    = -1;
      nvalid = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            nvalid++;
            if (lat < 0) lat = i;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, nv;
      logic [11:0] pat;

      vecs[0] = '{16384, 16384, 16384, 4096, 4096, 4096};
      vecs[1] = '{16384, 16384, 16384, 7168, 7168, 7168};
      vecs[2] = '{16384, 16384, 16384, 9472, 9472, 9472};
      vecs[3] = '{16384, 16384, 16384, 11200, 11200, 11200};
      vecs[4] = '{0, -32768, 32767, 8400, 208, 16591};
      vecs[5] = '{100000, -100000, -1, 14492, -8036, 12443};

      rst_n = 1'b0; clk_en = 1'b0; clear = 1'b0;
      set_raw(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mti", mti, 0);
      chk("rst_fb1", fbi1, 0);
      chk("rst_fb2", fbi2, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovr", overrun_count, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Table: successive EMA steps, including clamp and negative targets.
      for (int v = 0; v < 6; v++) begin
         set_raw(vecs[v].m, vecs[v].f1, vecs[v].f2);
         run_strobe(lat, nv);
         chk($sformatf("v%0d_lat", v), lat, 4);
         chk($sformatf("v%0d_nvalid", v), nv, 1);
         chk($sformatf("v%0d_mti", v), mti, vecs[v].em);
         chk($sformatf("v%0d_fb1", v), fbi1, vecs[v].ef1);
         chk($sformatf("v%0d_fb2", v), fbi2, vecs[v].ef2);
         $display("vec %0d: in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) lat=%0d",
                  v, vecs[v].m, vecs[v].f1, vecs[v].f2, mti, fbi1, fbi2, lat);
      end

      // Product clamp with a 2.0 weight on the adjacent channel.
      do_reset();
      set_raw(-16384, 32767, 0);
      run_strobe(lat, nv);
      chk("clamp_k_mti", k_mti, -4096);
      chk("clamp_k_fb1", k_fbi1, 8192);
      chk("clamp_k_fb2", k_fbi2, 0);
      chk("clamp_fb1_unity", fbi1, 8191);
      $display("clamp: k_out=(%0d,%0d,%0d) fb1_unity=%0d", k_mti, k_fbi1, k_fbi2, fbi1);

      // Strobes at N, N+1, N+3: only the first is processed.
      do_reset();
      set_raw(16384, 16384, 16384);
      pat = 12'b0000_0000_1011;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         clk_en = pat[c];
         if (c == 1) set_raw(0, 0, 0);
         @(posedge clk); #1;
         if (out_valid) nv++;
      end
      clk_en = 1'b0;
      chk("ovr_nvalid", nv, 1);
      chk("ovr_count", overrun_count, 2);
      chk("ovr_mti", mti, 4096);
      chk("ovr_fb1", fbi1, 4096);
      chk("ovr_fb2", fbi2, 4096);
      $display("overrun: commits=%0d count=%0d out=(%0d,%0d,%0d)", nv, overrun_count, mti, fbi1, fbi2);

      // clear during CH1 together with a strobe.
      set_raw(16384, 16384, 16384);
      nv = 0;
      for (int c = 0; c < 11; c++) begin
         clk_en = (c == 0 || c == 2);
         clear  = (c == 2);
         @(posedge clk); #1;
         if (out_valid) nv++;
         if (c == 2) begin
            chk("clr_mti", mti, 0);
            chk("clr_fb1", fbi1, 0);
            chk("clr_fb2", fbi2, 0);
            chk("clr_busy", busy, 0);
            chk("clr_ovr", overrun_count, 2);
         end
      end
      clk_en = 1'b0; clear = 1'b0;
      chk("clr_nvalid", nv, 0);
      run_strobe(lat, nv);
      chk("clr_after_mti", mti, 4096);
      chk("clr_after_lat", lat, 4);
      $display("clear: aborted, next commit mti=%0d lat=%0d ovr=%0d", mti, lat, overrun_count);

      // Asynchronous reset in the middle of CH2.
      nv = 0;
      for (int c = 0; c < 4; c++) begin
         clk_en = (c == 0);
         if (c < 3) begin
            @(posedge clk); #1;
            if (out_valid) nv++;
         end
      end
      clk_en = 1'b0;
      #4 rst_n = 1'b0;
      #1;
      chk("arst_mti", mti, 0);
      chk("arst_fb1", fbi1, 0);
      chk("arst_fb2", fbi2, 0);
      chk("arst_ovr", overrun_count, 0);
      chk("arst_busy", busy, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid) nv++;
      end
      chk("arst_nvalid", nv, 0);
      chk("arst_mti_hold", mti, 0);
      $display("async reset: out=(%0d,%0d,%0d) ovr=%0d pulses=%0d", mti, fbi1, fbi2, overrun_count, nv);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
